store_align: RTL and testbench

Store-side counterpart of the immediate/load extender in the pipelined CPU: it narrows and positions register data for `sw`/`sh`/`sb` rather than widening it. It sits between the MEM stage and the data memory port. It accepts a store (address, register data, width) over a valid/ready handshake and buffers it in a 2-entry FIFO. It emits a word-aligned write with byte enables and replicated lane data, and optionally flags misaligned stores.

---
 rtl/store_align.sv | 136 +++++++++++++
 tb/tb_store_align.sv | 204 ++++++++++++++++++++
 2 files changed

// File: rtl/store_align.sv
// Store lane aligner: queues sw/sh/sb stores in a 2-entry FIFO and emits word-aligned writes with byte enables.
// Optional macro STORE_MISALIGN_TRAP_EN drops misaligned/illegal stores and reports them on Misalign/BadAddr.
module store_align #(
  parameter int unsigned DEPTH = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [1:0]  StoreOp,
  input  logic [31:0] Addr,
  input  logic [31:0] WData,
  output logic        mem_valid,
  input  logic        mem_ready,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic [3:0]  mem_be,
  output logic        Misalign,
  output logic [31:0] BadAddr
);

  localparam int unsigned CntW = 2;
  localparam logic [CntW-1:0] Full = CntW'(DEPTH);

  typedef struct packed {
    logic [29:0] waddr;
    logic [31:0] data;
    logic [3:0]  be;
  } entry_t;

  entry_t          entry_q [2];
  entry_t          entry_d [2];
  entry_t          new_entry;
  entry_t          head;
  logic            wr_ptr_q, wr_ptr_d;
  logic            rd_ptr_q, rd_ptr_d;
  logic [CntW-1:0] count_q, count_d;
  logic            push, pop, enq;

  assign in_ready  = (count_q != Full);
  assign mem_valid = (count_q != '0);
  assign push      = in_valid && in_ready;
  assign pop       = mem_valid && mem_ready;

  // Lane placement; an illegal op falls through to word handling.
  always_comb begin
    new_entry.waddr = Addr[31:2];
    new_entry.data  = WData;
    new_entry.be    = 4'b1111;
    case (StoreOp)
      2'b01: begin
        new_entry.be   = Addr[1] ? 4'b1100 : 4'b0011;
        new_entry.data = {2{WData[15:0]}};
      end
      2'b10: begin
        new_entry.be   = 4'b0001 << Addr[1:0];
        new_entry.data = {4{WData[7:0]}};
      end
      default: ;
    endcase
  end

`ifdef STORE_MISALIGN_TRAP_EN
  logic        bad;
  logic        misalign_q, misalign_d;
  logic [31:0] bad_addr_q, bad_addr_d;

  always_comb begin
    case (StoreOp)
      2'b00:   bad = (Addr[1:0] != 2'b00);
      2'b01:   bad = Addr[0];
      2'b10:   bad = 1'b0;
      default: bad = 1'b1;
    endcase
    misalign_d = push && bad;
    bad_addr_d = misalign_d ? Addr : bad_addr_q;
  end

  assign enq = push && !bad;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      misalign_q <= 1'b0;
      bad_addr_q <= '0;
    end else begin
      misalign_q <= misalign_d;
      bad_addr_q <= bad_addr_d;
    end
  end

  assign Misalign = misalign_q;
  assign BadAddr  = bad_addr_q;
`else
  assign enq      = push;
  assign Misalign = 1'b0;
  assign BadAddr  = '0;
`endif

  // FIFO pointer/count update.
  always_comb begin
    entry_d  = entry_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (enq) begin
      entry_d[wr_ptr_q] = new_entry;
      wr_ptr_d          = ~wr_ptr_q;
    end
    if (pop) begin
      rd_ptr_d = ~rd_ptr_q;
    end
    count_d = count_q + CntW'(enq) - CntW'(pop);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < 2; i++) begin
        entry_q[i] <= '0;
      end
      wr_ptr_q <= 1'b0;
      rd_ptr_q <= 1'b0;
      count_q  <= '0;
    end else begin
      entry_q  <= entry_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Head entry is masked to zero when empty so be is never live without valid.
  assign head      = entry_q[rd_ptr_q];
  assign mem_addr  = mem_valid ? {head.waddr, 2'b00} : '0;
  assign mem_wdata = mem_valid ? head.data : '0;
  assign mem_be    = mem_valid ? head.be : '0;

endmodule

// File: tb/tb_store_align.sv
// Bench for store_align: directed scenarios then random traffic against a queue-based reference model.
module tb_store_align;

  logic        clk = 1'b0;
  logic        reset;
  logic        in_valid;
  logic        in_ready;
  logic [1:0]  StoreOp;
  logic [31:0] Addr;
  logic [31:0] WData;
  logic        mem_valid;
  logic        mem_ready;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_be;
  logic        Misalign;
  logic [31:0] BadAddr;

  always #5 clk = ~clk;

  store_align #(.DEPTH(2)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .StoreOp(StoreOp), .Addr(Addr), .WData(WData),
    .mem_valid(mem_valid), .mem_ready(mem_ready), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_be(mem_be), .Misalign(Misalign), .BadAddr(BadAddr)
  );

  typedef struct {
    logic [31:0] addr;
    logic [31:0] data;
    logic [3:0]  be;
  } exp_t;

  exp_t        mq[$];
  logic        exp_mis = 1'b0;
  logic [31:0] exp_bad = 32'h0;
  int          errors = 0;
  int          checks = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic is_bad(input logic [1:0] op, input logic [31:0] a);
    return (op == 2'd3) || (op == 2'd0 && (a % 4) != 0) || (op == 2'd1 && (a % 2) != 0);
  endfunction

  // Expected memory write derived from the store width rules.
  function automatic exp_t form(input logic [1:0] op, input logic [31:0] a, input logic [31:0] d);
    exp_t e;
    e.addr = a & ~32'h3;
    case (op)
      2'd1: begin
        e.be   = 4'(32'h3 << (a & 32'h2));
        e.data = (d & 32'hFFFF) * 32'h0001_0001;
      end
      2'd2: begin
        e.be   = 4'(32'h1 << (a % 4));
        e.data = (d & 32'hFF) * 32'h0101_0101;
      end
      default: begin
        e.be   = 4'hF;
        e.data = d;
      end
    endcase
    return e;
  endfunction

  task automatic model_edge();
    logic acc, pp;
    acc = in_valid && (mq.size() != 2);
    pp  = (mq.size() != 0) && mem_ready;
    exp_mis = 1'b0;
    if (pp) void'(mq.pop_front());
    if (acc) begin
`ifdef STORE_MISALIGN_TRAP_EN
      if (is_bad(StoreOp, Addr)) begin
        exp_mis = 1'b1;
        exp_bad = Addr;
      end else begin
        mq.push_back(form(StoreOp, Addr, WData));
      end
`else
      mq.push_back(form(StoreOp, Addr, WData));
`endif
    end
  endtask

  task automatic check_outputs();
    exp_t h;
    h = '{32'h0, 32'h0, 4'h0};
    if (mq.size() != 0) h = mq[0];
    check("in_ready",  32'(in_ready),  32'(mq.size() != 2));
    check("mem_valid", 32'(mem_valid), 32'(mq.size() != 0));
    check("mem_addr",  mem_addr,  h.addr);
    check("mem_wdata", mem_wdata, h.data);
    check("mem_be",    32'(mem_be), 32'(h.be));
    check("Misalign",  32'(Misalign), 32'(exp_mis));
    check("BadAddr",   BadAddr, exp_bad);
  endtask

  // Drive inputs on the falling edge, advance one clock, check on the next falling edge.
  task automatic step(input logic v, input logic [1:0] op, input logic [31:0] a,
                      input logic [31:0] d, input logic mr);
    in_valid  = v;
    StoreOp   = op;
    Addr      = a;
    WData     = d;
    mem_ready = mr;
    model_edge();
    @(negedge clk);
    check_outputs();
  endtask

  initial begin
    reset = 1'b0; in_valid = 1'b0; StoreOp = 2'd0; Addr = 32'h0; WData = 32'h0; mem_ready = 1'b1;
    repeat (2) @(negedge clk);
    reset = 1'b1;
    check_outputs();

    // Basic word store, one cycle latency, drains next cycle.
    step(1'b1, 2'd0, 32'h100, 32'h1234_5678, 1'b1);
    check("tp_sw_valid", 32'(mem_valid), 32'd1);
    check("tp_sw_addr",  mem_addr, 32'h100);
    check("tp_sw_be",    32'(mem_be), 32'hF);
    check("tp_sw_data",  mem_wdata, 32'h1234_5678);
    step(1'b0, 2'd0, 32'h0, 32'h0, 1'b1);
    check("tp_sw_drain", 32'(mem_valid), 32'd0);

    // Lane placement for half and byte.
    step(1'b1, 2'd1, 32'h102, 32'hFFFF_ABCD, 1'b1);
    check("tp_sh_be",   32'(mem_be), 32'hC);
    check("tp_sh_data", mem_wdata, 32'hABCD_ABCD);
    step(1'b1, 2'd2, 32'h103, 32'h55, 1'b1);
    check("tp_sb_be",   32'(mem_be), 32'h8);
    check("tp_sb_data", mem_wdata, 32'h5555_5555);
    step(1'b0, 2'd0, 32'h0, 32'h0, 1'b1);

    // Backpressure: A, B accepted, C stalls, then drain in order.
    step(1'b1, 2'd0, 32'h200, 32'hAAAA_0001, 1'b0);
    step(1'b1, 2'd0, 32'h204, 32'hBBBB_0002, 1'b0);
    check("tp_full_ready", 32'(in_ready), 32'd0);
    step(1'b1, 2'd0, 32'h208, 32'hCCCC_0003, 1'b0);
    check("tp_stall_head", mem_wdata, 32'hAAAA_0001);
    step(1'b1, 2'd0, 32'h208, 32'hCCCC_0003, 1'b1);
    check("tp_order_b", mem_wdata, 32'hBBBB_0002);
    step(1'b1, 2'd0, 32'h208, 32'hCCCC_0003, 1'b1);
    check("tp_order_c", mem_wdata, 32'hCCCC_0003);
    step(1'b0, 2'd0, 32'h0, 32'h0, 1'b1);

    // Push and pop together at count 1.
    step(1'b1, 2'd2, 32'h300, 32'h11, 1'b0);
    step(1'b1, 2'd2, 32'h301, 32'h22, 1'b1);
    check("tp_pp_valid", 32'(mem_valid), 32'd1);
    check("tp_pp_head",  mem_wdata, 32'h2222_2222);
    check("tp_pp_ready", 32'(in_ready), 32'd1);
    step(1'b0, 2'd0, 32'h0, 32'h0, 1'b1);

    // Misaligned word store.
    step(1'b1, 2'd0, 32'h101, 32'hDEAD_BEEF, 1'b1);
`ifdef STORE_MISALIGN_TRAP_EN
    check("tp_mis_pulse", 32'(Misalign), 32'd1);
    check("tp_mis_addr",  BadAddr, 32'h101);
    check("tp_mis_valid", 32'(mem_valid), 32'd0);
`else
    check("tp_mis_addr",  mem_addr, 32'h100);
    check("tp_mis_be",    32'(mem_be), 32'hF);
`endif
    step(1'b0, 2'd0, 32'h0, 32'h0, 1'b1);
    check("tp_mis_once", 32'(Misalign), 32'd0);

    // Reset with two entries queued.
    step(1'b1, 2'd0, 32'h400, 32'h0404_0404, 1'b0);
    step(1'b1, 2'd0, 32'h404, 32'h0808_0808, 1'b0);
    in_valid = 1'b0;
    reset = 1'b0;
    #1;
    check("tp_rst_valid", 32'(mem_valid), 32'd0);
    check("tp_rst_be",    32'(mem_be), 32'd0);
    mq.delete();
    exp_mis = 1'b0;
    exp_bad = 32'h0;
    @(negedge clk);
    reset = 1'b1;
    check_outputs();
    repeat (3) step(1'b0, 2'd0, 32'h0, 32'h0, 1'b1);

    // Random traffic.
    for (int i = 0; i < 3000; i++) begin
      logic [31:0] a;
      a = {20'h0, 12'($urandom)};
      step($urandom_range(0, 3) != 0, 2'($urandom_range(0, 3)), a, $urandom,
           $urandom_range(0, 9) < 7);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
